snn_wta_layer: RTL and testbench
================================

// Module: snn_wta_layer
// PURPOSE
//   Parametrised single-layer spiking network core with N_IN presynaptic spike inputs and N_OUT leaky
//   integrate-and-fire output neurons. Binary synapses are held in an on-chip weight matrix, and the
//   layer applies winner-take-all lateral inhibition with per-winner refractory time.
//   An optional STDP-style update rewrites the winning neuron's weight row after each output spike.
//   Sits behind the input-encoding neurons; replaces the fixed 25x10 synapse/out-neuron array.
// PARAMETERS
//   N_IN    25  presynaptic inputs (weight row width)
//   N_OUT   10  output neurons (weight rows)
//   VW      8   membrane potential width, unsigned
//   THRESH  12  firing threshold (v_next >= THRESH fires)
//   LEAK    1   per-cycle leak subtracted while integrating
//   REFRAC  4   winner refractory cycles
//   INHIB   8   lateral inhibition cycles applied to non-winners
//   TRACE   3   presynaptic trace window in cycles (LTP eligibility)
// PORTS
//   clk          in   1                   clock, rising edge
//   rst          in   1                   synchronous reset, active-high
//   learn        in   1                   1 = STDP row update after each output spike
//   pre_spike    in   N_IN                presynaptic spikes, sampled every edge
//   rand_bits    in   N_IN                random depression mask, sampled in UPDATE
//   w_wr_en      in   1                   weight row write request
//   w_wr_addr    in   $clog2(N_OUT)       row to write
//   w_wr_data    in   N_IN                row data
//   w_wr_ready   out  1                   write accepted when w_wr_en & w_wr_ready
//   w_rd_addr    in   $clog2(N_OUT)       row read address
//   w_rd_data    out  N_IN                W[w_rd_addr], combinational; 0 if addr >= N_OUT
//   spike        out  N_OUT               registered one-hot output spikes
//   winner_valid out  1                   1-cycle pulse coincident with spike != 0
//   winner_idx   out  $clog2(N_OUT)       index of the last winner; held between spikes
// BEHAVIOUR
//   Reset: W=0, all v=0, all traces=0, refractory/inhibit counters=0, state=RUN, spike=0,
//     winner_valid=0, winner_idx=0, w_wr_ready=1. Reset is allowed mid-UPDATE and aborts it.
//   Trace per input i: on pre_spike[i], tr[i] is set to TRACE. Otherwise it decrements, saturating at 0.
//   Neuron j, each edge:
//     - If ref[j]>0 or inh[j]>0: v[j]=0, decrement each nonzero counter.
//     - Else: s = popcount(pre_spike & W[j]), width $clog2(N_IN+1).
//       v_next = v + s - LEAK. Floor at 0; saturate at 2^VW-1.
//   Fire: candidates are integrating neurons with v_next >= THRESH. The lowest index wins; only one
//     neuron fires per edge.
//     - On that edge: spike[w]=1, winner_valid=1, winner_idx=w, all v=0.
//     - ref[w]=REFRAC. inh[k]=INHIB for all k!=w (counters are reloaded even if already nonzero).
//   Latency: pre_spike at edge k is integrated at edge k; spike is visible after edge k.
//   Constant drive above threshold gives a winner period of REFRAC+1 cycles.
//   FSM RUN/UPDATE:
//     - RUN -> UPDATE on a fire edge with learn=1. The same edge latches mask = pre_spike | (tr!=0),
//       using the pre-decrement tr.
//     - UPDATE lasts exactly 1 cycle: W[winner_idx] <= mask | (W[winner_idx] & ~rand_bits); then RUN.
//     - learn=0: never leaves RUN.
//   Write port:
//     - w_wr_ready = (state==RUN).
//     - An accepted write updates the row at that edge, visible on w_rd_data next cycle.
//     - w_wr_addr >= N_OUT: accepted and dropped.
//     - A write on the fire edge lands first; UPDATE then modifies the newly written row.
//   Neuron integration continues unchanged during UPDATE.
// TESTING
//   T1 reset: run random traffic, pulse rst mid-UPDATE -> next cycle spike=0, winner_valid=0,
//      w_wr_ready=1, all rows read 0; all-ones pre_spike for 20 cycles -> no spike.
//   T2 period: W[3]=all ones, others 0, pre_spike all ones -> spike[3] after first edge, winner_idx=3;
//      repeats every 5 cycles; no other spike bit ever set.
//   T3 WTA tie: W[2]=W[5]=all ones, constant all-ones input -> only spike[2], every 5 cycles;
//      neuron 5 stays silent because inh is reloaded before it expires.
//   T4 leak: W[0]=bits 0..3, pre bits 0..3 every cycle -> v=3,6,9,12, spike[0] on edge 4;
//      bits 0..1 on alternate cycles (v goes +1, -1 floored) -> never fires in 100 cycles.
//   T5 learn: learn=1, W[1]=bits 0..11 plus bit 24, input bits 0..11 plus bit 20 at one edge,
//      rand_bits all ones -> spike[1]; next cycle w_wr_ready=0; then W[1]=bits 0..11 plus bit 20.
//      Repeat with rand_bits=0 -> bit 24 retained.
//   T6 write port: write addr 12 -> no row changes; write held during UPDATE -> not accepted until
//      ready returns; write W[4] on a fire edge of neuron 4 -> UPDATE applies to the new row.

Source files
------------

// File: rtl/snn_wta_layer_if.sv
// Weight-memory access bus of the spiking WTA layer: a ready-gated row write
// port plus a combinational row read port.
interface snn_wta_layer_if #(
    parameter int N_IN  = 25,
    parameter int N_OUT = 10
);
    localparam int AW = $clog2(N_OUT);

    logic            w_wr_en;
    logic [AW-1:0]   w_wr_addr;
    logic [N_IN-1:0] w_wr_data;
    logic            w_wr_ready;
    logic [AW-1:0]   w_rd_addr;
    logic [N_IN-1:0] w_rd_data;

    modport master (
        output w_wr_en, w_wr_addr, w_wr_data, w_rd_addr,
        input  w_wr_ready, w_rd_data
    );

    modport slave (
        input  w_wr_en, w_wr_addr, w_wr_data, w_rd_addr,
        output w_wr_ready, w_rd_data
    );
endinterface

// File: rtl/snn_wta_layer.sv
// Single-layer leaky integrate-and-fire core with binary synapses, winner-take-all
// lateral inhibition and an optional one-cycle STDP rewrite of the winner's weight row.
module snn_wta_layer #(
    parameter int N_IN   = 25,
    parameter int N_OUT  = 10,
    parameter int VW     = 8,
    parameter int THRESH = 12,
    parameter int LEAK   = 1,
    parameter int REFRAC = 4,
    parameter int INHIB  = 8,
    parameter int TRACE  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     learn,
    input  logic [N_IN-1:0]          pre_spike,
    input  logic [N_IN-1:0]          rand_bits,
    snn_wta_layer_if.slave           wbus,
    output logic [N_OUT-1:0]         spike,
    output logic                     winner_valid,
    output logic [$clog2(N_OUT)-1:0] winner_idx
);
    localparam int AW = $clog2(N_OUT);
    localparam int SW = $clog2(N_IN + 1);
    localparam int TW = $clog2(TRACE + 1);
    localparam int RW = $clog2(REFRAC + 1);
    localparam int IW = $clog2(INHIB + 1);
    localparam int XW = VW + SW + 1;

    localparam logic [XW-1:0] LEAK_X = XW'(LEAK);
    localparam logic [XW-1:0] VMAX   = {{(XW-VW){1'b0}}, {VW{1'b1}}};
    localparam logic [VW-1:0] THR    = VW'(THRESH);

    typedef enum logic [0:0] {RUN, UPDATE} state_t;

    state_t          state, state_next;
    logic [N_IN-1:0] w_mem   [N_OUT];
    logic [VW-1:0]   v       [N_OUT];
    logic [RW-1:0]   ref_cnt [N_OUT];
    logic [IW-1:0]   inh_cnt [N_OUT];
    logic [TW-1:0]   tr      [N_IN];
    logic [N_IN-1:0] ltp_mask;

    logic [VW-1:0]    v_next [N_OUT];
    logic [N_OUT-1:0] integrating;
    logic [N_OUT-1:0] cand;
    logic [N_IN-1:0]  tr_live;
    logic             fire;
    logic [AW-1:0]    win;
    logic             wr_accept;

    function automatic logic [SW-1:0] popcount(input logic [N_IN-1:0] x);
        logic [SW-1:0] c;
        c = '0;
        for (int i = 0; i < N_IN; i++) begin
            c = c + SW'(x[i]);
        end
        return c;
    endfunction

    // Membrane update candidates, computed in a wide sum so the floor/saturation is exact.
    always_comb begin
        integrating = '0;
        cand        = '0;
        for (int j = 0; j < N_OUT; j++) begin
            logic [XW-1:0] sum;
            integrating[j] = (ref_cnt[j] == '0) && (inh_cnt[j] == '0);
            sum = XW'(v[j]) + XW'(popcount(pre_spike & w_mem[j]));
            if (sum < LEAK_X) begin
                v_next[j] = '0;
            end else if ((sum - LEAK_X) > VMAX) begin
                v_next[j] = '1;
            end else begin
                v_next[j] = VW'(sum - LEAK_X);
            end
            cand[j] = integrating[j] && (v_next[j] >= THR);
        end
    end

    // Lowest-index candidate wins; scanning downward leaves the smallest index last.
    always_comb begin
        fire = |cand;
        win  = '0;
        for (int j = N_OUT - 1; j >= 0; j--) begin
            if (cand[j]) begin
                win = AW'(j);
            end
        end
        for (int i = 0; i < N_IN; i++) begin
            tr_live[i] = (tr[i] != '0);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (fire && learn) state_next = UPDATE;
            UPDATE:  state_next = RUN;
            default: state_next = RUN;
        endcase
        wbus.w_wr_ready = (state == RUN);
        wr_accept       = wbus.w_wr_en && (state == RUN);
        wbus.w_rd_data  = '0;
        if (32'(wbus.w_rd_addr) < N_OUT) begin
            wbus.w_rd_data = w_mem[wbus.w_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            spike        <= '0;
            winner_valid <= 1'b0;
            winner_idx   <= '0;
            ltp_mask     <= '0;
            for (int i = 0; i < N_IN; i++) begin
                tr[i] <= '0;
            end
            for (int j = 0; j < N_OUT; j++) begin
                w_mem[j]   <= '0;
                v[j]       <= '0;
                ref_cnt[j] <= '0;
                inh_cnt[j] <= '0;
            end
        end else begin
            state        <= state_next;
            winner_valid <= fire;
            spike        <= fire ? (N_OUT'(1) << win) : '0;
            if (fire) begin
                winner_idx <= win;
            end
            if (state == RUN && fire && learn) begin
                ltp_mask <= pre_spike | tr_live;
            end

            for (int i = 0; i < N_IN; i++) begin
                if (pre_spike[i]) begin
                    tr[i] <= TW'(TRACE);
                end else if (tr[i] != '0) begin
                    tr[i] <= tr[i] - 1'b1;
                end
            end

            // A fire clears every membrane and reloads inhibition even on already-inhibited neurons.
            for (int j = 0; j < N_OUT; j++) begin
                if (fire) begin
                    v[j] <= '0;
                    if (AW'(j) == win) begin
                        ref_cnt[j] <= RW'(REFRAC);
                    end else begin
                        inh_cnt[j] <= IW'(INHIB);
                        if (ref_cnt[j] != '0) ref_cnt[j] <= ref_cnt[j] - 1'b1;
                    end
                end else if (!integrating[j]) begin
                    v[j] <= '0;
                    if (ref_cnt[j] != '0) ref_cnt[j] <= ref_cnt[j] - 1'b1;
                    if (inh_cnt[j] != '0) inh_cnt[j] <= inh_cnt[j] - 1'b1;
                end else begin
                    v[j] <= v_next[j];
                end

                // Writes are only accepted in RUN, so they never collide with the UPDATE rewrite.
                if (wr_accept && (wbus.w_wr_addr == AW'(j))) begin
                    w_mem[j] <= wbus.w_wr_data;
                end else if (state == UPDATE && winner_idx == AW'(j)) begin
                    w_mem[j] <= ltp_mask | (w_mem[j] & ~rand_bits);
                end
            end
        end
    end
endmodule

// File: tb/tb_snn_wta_layer.sv
// Directed bench for snn_wta_layer: expected winner events go into a scoreboard
// queue that a negedge monitor drains whenever winner_valid is presented.
module tb_snn_wta_layer;
    localparam int N_IN  = 25;
    localparam int N_OUT = 10;
    localparam int AW    = 4;
    localparam logic [N_IN-1:0] ALL1 = '1;

    typedef struct {
        int            at;
        logic [AW-1:0] idx;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             learn;
    logic [N_IN-1:0]  pre_spike;
    logic [N_IN-1:0]  rand_bits;
    logic [N_OUT-1:0] spike;
    logic             winner_valid;
    logic [AW-1:0]    winner_idx;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   valid_seen = 0;
    int   base;
    int   v0;
    exp_t sb_q[$];
    exp_t e;

    snn_wta_layer_if #(.N_IN(N_IN), .N_OUT(N_OUT)) wbus();

    snn_wta_layer dut (
        .clk          (clk),
        .rst          (rst),
        .learn        (learn),
        .pre_spike    (pre_spike),
        .rand_bits    (rand_bits),
        .wbus         (wbus),
        .spike        (spike),
        .winner_valid (winner_valid),
        .winner_idx   (winner_idx)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every winner pulse must match the head of the scoreboard at the right edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].at < cyc) begin
            tests++;
            fails++;
            $display("[TB] FAIL missing_spike: no winner at edge %0d, expected idx %0d", sb_q[0].at, sb_q[0].idx);
            void'(sb_q.pop_front());
        end
        if (winner_valid === 1'b1) begin
            valid_seen++;
            if (sb_q.size() > 0 && sb_q[0].at == cyc) begin
                e = sb_q.pop_front();
                checkOutput("winner_idx", 32'(winner_idx), 32'(e.idx));
                checkOutput("spike_onehot", 32'(spike), 32'(1) << e.idx);
            end else begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_spike: edge %0d idx %0d spike 0x%0h, expected none", cyc, winner_idx, spike);
            end
        end else if (winner_valid === 1'b0 && spike !== '0) begin
            tests++;
            fails++;
            $display("[TB] FAIL spike_without_valid: spike 0x%0h, expected 0x0", spike);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N_IN-1:0] pre, input int n);
        pre_spike = pre;
        repeat (n) tick();
    endtask

    task automatic pushExpect(input int idx, input int at);
        exp_t x;
        x.at  = at;
        x.idx = AW'(idx);
        sb_q.push_back(x);
    endtask

    task automatic doReset();
        rst            = 1'b1;
        learn          = 1'b0;
        pre_spike      = '0;
        rand_bits      = '0;
        wbus.w_wr_en   = 1'b0;
        wbus.w_wr_addr = '0;
        wbus.w_wr_data = '0;
        wbus.w_rd_addr = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic writeRow(input int addr, input logic [N_IN-1:0] data);
        wbus.w_wr_en   = 1'b1;
        wbus.w_wr_addr = AW'(addr);
        wbus.w_wr_data = data;
        tick();
        wbus.w_wr_en   = 1'b0;
    endtask

    task automatic readRow(input int addr, input logic [N_IN-1:0] expected, input string name);
        wbus.w_rd_addr = AW'(addr);
        #1;
        checkOutput(name, 32'(wbus.w_rd_data), 32'(expected));
    endtask

    initial begin
        rst            = 1'b1;
        learn          = 1'b0;
        pre_spike      = '0;
        rand_bits      = '0;
        wbus.w_wr_en   = 1'b0;
        wbus.w_wr_addr = '0;
        wbus.w_wr_data = '0;
        wbus.w_rd_addr = '0;

        // T1: reset values, then reset aborting an UPDATE
        doReset();
        checkOutput("rst_spike", 32'(spike), 0);
        checkOutput("rst_winner_valid", 32'(winner_valid), 0);
        checkOutput("rst_winner_idx", 32'(winner_idx), 0);
        checkOutput("rst_ready", 32'(wbus.w_wr_ready), 1);
        writeRow(0, ALL1);
        learn = 1'b1;
        pushExpect(0, cyc + 1);
        applyStimulus(ALL1, 1);
        checkOutput("t1_ready_in_update", 32'(wbus.w_wr_ready), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t1_abort_spike", 32'(spike), 0);
        checkOutput("t1_abort_valid", 32'(winner_valid), 0);
        checkOutput("t1_abort_ready", 32'(wbus.w_wr_ready), 1);
        for (int r = 0; r < N_OUT; r++) readRow(r, '0, "t1_row_cleared");
        v0 = valid_seen;
        applyStimulus(ALL1, 20);
        pre_spike = '0;
        checkOutput("t1_silent_after_reset", 32'(valid_seen - v0), 0);

        // T2: single active row, period REFRAC+1
        doReset();
        writeRow(3, ALL1);
        base = cyc;
        for (int k = 0; k < 4; k++) pushExpect(3, base + 1 + 5 * k);
        applyStimulus(ALL1, 1);
        checkOutput("t2_first_idx", 32'(winner_idx), 3);
        checkOutput("t2_first_spike", 32'(spike), 32'h8);
        applyStimulus(ALL1, 16);
        applyStimulus('0, 6);
        checkOutput("t2_idx_held", 32'(winner_idx), 3);

        // T3: tie between rows 2 and 5, lower index always wins
        doReset();
        writeRow(2, ALL1);
        writeRow(5, ALL1);
        base = cyc;
        for (int k = 0; k < 4; k++) pushExpect(2, base + 1 + 5 * k);
        applyStimulus(ALL1, 17);
        applyStimulus('0, 10);

        // T4: leak — steady drive fires on the 4th edge, alternating drive never fires
        doReset();
        writeRow(0, 25'h000000F);
        base = cyc;
        pushExpect(0, base + 4);
        applyStimulus(25'h000000F, 3);
        checkOutput("t4_no_early_fire", 32'(winner_valid), 0);
        applyStimulus(25'h000000F, 1);
        checkOutput("t4_fire_edge4", 32'(winner_valid), 1);
        applyStimulus('0, 6);
        v0 = valid_seen;
        for (int k = 0; k < 100; k++) applyStimulus(k[0] ? 25'h0 : 25'h3, 1);
        pre_spike = '0;
        checkOutput("t4_alternate_silent", 32'(valid_seen - v0), 0);

        // T5: learning with full depression, then with none
        doReset();
        learn     = 1'b1;
        rand_bits = ALL1;
        writeRow(1, 25'h1000FFF);
        pushExpect(1, cyc + 2);
        applyStimulus(25'h0100FFF, 2);
        pre_spike = '0;
        checkOutput("t5_ready_low", 32'(wbus.w_wr_ready), 0);
        tick();
        checkOutput("t5_ready_back", 32'(wbus.w_wr_ready), 1);
        readRow(1, 25'h0100FFF, "t5_row_depressed");

        doReset();
        learn     = 1'b1;
        rand_bits = '0;
        writeRow(1, 25'h1000FFF);
        pushExpect(1, cyc + 2);
        applyStimulus(25'h0100FFF, 2);
        applyStimulus('0, 1);
        readRow(1, 25'h1100FFF, "t5_row_retained");

        // T6a: out-of-range write is dropped; out-of-range read returns 0
        doReset();
        writeRow(12, ALL1);
        for (int r = 0; r < N_OUT; r++) readRow(r, '0, "t6_oob_write_dropped");
        readRow(12, '0, "t6_oob_read_zero");

        // T6b: write held across UPDATE is accepted only once ready returns
        doReset();
        learn = 1'b1;
        writeRow(0, ALL1);
        pushExpect(0, cyc + 1);
        applyStimulus(ALL1, 1);
        pre_spike      = '0;
        wbus.w_wr_en   = 1'b1;
        wbus.w_wr_addr = AW'(7);
        wbus.w_wr_data = 25'h0AAAAAA;
        checkOutput("t6_ready_low", 32'(wbus.w_wr_ready), 0);
        tick();
        checkOutput("t6_ready_high", 32'(wbus.w_wr_ready), 1);
        readRow(7, '0, "t6_write_not_yet");
        tick();
        wbus.w_wr_en = 1'b0;
        readRow(7, 25'h0AAAAAA, "t6_write_landed");

        // T6c: write on the fire edge lands first, UPDATE then rewrites that new row
        doReset();
        learn     = 1'b1;
        rand_bits = 25'h0100000;
        writeRow(4, ALL1);
        wbus.w_wr_en   = 1'b1;
        wbus.w_wr_addr = AW'(4);
        wbus.w_wr_data = 25'h1F00000;
        pushExpect(4, cyc + 1);
        applyStimulus(25'h0001FFF, 1);
        wbus.w_wr_en = 1'b0;
        applyStimulus('0, 1);
        readRow(4, 25'h1E01FFF, "t6_update_on_new_row");

        repeat (3) tick();
        while (sb_q.size() > 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL leftover_expect: edge %0d idx %0d never seen", sb_q[0].at, sb_q[0].idx);
            void'(sb_q.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
